// File: rtl/buff_pc_pkg.sv
// Opcode, function-field and cycle-length constants shared by the Buff_PC
// generator and its length decoder.
package buff_pc_pkg;

  localparam logic [4:0] OP_ALU       = 5'b00000;
  localparam logic [4:0] OP_LHI       = 5'b00001;
  localparam logic [4:0] OP_LLI       = 5'b00010;
  localparam logic [4:0] OP_LDRRI     = 5'b00011;
  localparam logic [4:0] OP_LDRRR     = 5'b00100;
  localparam logic [4:0] OP_STRRI     = 5'b00101;
  localparam logic [4:0] OP_STRRR_CMP = 5'b00110;
  localparam logic [4:0] OP_ADDI      = 5'b00111;
  localparam logic [4:0] OP_SUBI      = 5'b01000;
  localparam logic [4:0] OP_MOV       = 5'b01011;
  localparam logic [4:0] OP_JMP       = 5'b10000;
  localparam logic [4:0] OP_JALRL     = 5'b10001;
  localparam logic [4:0] OP_JALRR     = 5'b10010;
  localparam logic [4:0] OP_JR        = 5'b10011;
  localparam logic [4:0] OP_BCOND     = 5'b11000;
  localparam logic [4:0] OP_BAL       = 5'b11001;
  localparam logic [4:0] OP_IO        = 5'b11100;

  localparam logic [1:0] F_STRRR = 2'b00;
  localparam logic [1:0] F_CMP   = 2'b01;
  localparam logic [1:0] F_OUTR  = 2'b00;
  localparam logic [1:0] F_HLT   = 2'b01;

  localparam int LEN_SHORT = 2;
  localparam int LEN_ALU   = 3;
  localparam int LEN_STORE = 3;
  localparam int LEN_LOAD  = 4;
  localparam int LEN_JAL   = 3;

endpackage

// File: rtl/buff_pc_len_decode.sv
// Maps major opcode and function field to the Cnt value of the final cycle.
module buff_pc_len_decode
  import buff_pc_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic [4:0]       ins_m,
  input  logic [1:0]       ins_l,
  output logic [CNT_W-1:0] last
);

  always_comb begin
    last = CNT_W'(LEN_SHORT);
    case (ins_m)
      OP_ALU:                 last = CNT_W'(LEN_ALU);
      OP_LDRRI, OP_LDRRR:     last = CNT_W'(LEN_LOAD);
      OP_STRRI:               last = CNT_W'(LEN_STORE);
      OP_ADDI, OP_SUBI:       last = CNT_W'(LEN_ALU);
      OP_JALRL, OP_JALRR:     last = CNT_W'(LEN_JAL);
      // Only STRrr takes the store length; CMP and the reserved 1x codes are short.
      OP_STRRR_CMP:           last = (ins_l == F_STRRR) ? CNT_W'(LEN_STORE)
                                                        : CNT_W'(LEN_SHORT);
      default:                last = CNT_W'(LEN_SHORT);
    endcase
  end

endmodule

// File: rtl/buff_pc_signal_gen.sv
// Raises Buff_PC in the last cycle of each instruction so the controller
// latches the next PC and restarts Cnt; purely combinational.
module buff_pc_signal_gen
  import buff_pc_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic [CNT_W-1:0] Cnt,
  input  logic [4:0]       InsM,
  input  logic [1:0]       InsL,
  output logic             Buff_PC
);

  logic [CNT_W-1:0] last;
  logic             unused_clk;

  assign unused_clk = clk;

  buff_pc_len_decode #(.CNT_W(CNT_W)) u_len_decode (
    .ins_m (InsM),
    .ins_l (InsL),
    .last  (last)
  );

  // >= rather than == so an overrun counter still terminates the instruction.
  assign Buff_PC = !Rst && (Cnt != '0) && (Cnt >= last);

endmodule

// File: tb/tb_buff_pc_signal_gen.sv
// Bench for buff_pc_signal_gen: closed-loop counter model with an expected
// terminal-count queue, plus directed reset and overrun checks.
module tb_buff_pc_signal_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cnt;
  logic [4:0] ins_m;
  logic [1:0] ins_l;
  logic       buff_pc;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  // {InsM, InsL, LAST} for the 25 defined instructions
  localparam logic [9:0] SWEEP[25] = '{
    {5'b00000, 2'b00, 3'd3}, {5'b00000, 2'b01, 3'd3},
    {5'b00000, 2'b10, 3'd3}, {5'b00000, 2'b11, 3'd3},
    {5'b00001, 2'b00, 3'd2}, {5'b00010, 2'b00, 3'd2},
    {5'b00011, 2'b00, 3'd4}, {5'b00100, 2'b10, 3'd4},
    {5'b00101, 2'b00, 3'd3}, {5'b00110, 2'b00, 3'd3},
    {5'b00110, 2'b01, 3'd2}, {5'b00111, 2'b00, 3'd3},
    {5'b01000, 2'b00, 3'd3}, {5'b01011, 2'b00, 3'd2},
    {5'b11000, 2'b00, 3'd2}, {5'b11000, 2'b01, 3'd2},
    {5'b11000, 2'b10, 3'd2}, {5'b11000, 2'b11, 3'd2},
    {5'b11001, 2'b00, 3'd2}, {5'b10000, 2'b00, 3'd2},
    {5'b10001, 2'b00, 3'd3}, {5'b10010, 2'b00, 3'd3},
    {5'b10011, 2'b00, 3'd2}, {5'b11100, 2'b00, 3'd2},
    {5'b11100, 2'b01, 3'd2}
  };

  always #5 clk = ~clk;

  buff_pc_signal_gen #(.CNT_W(3)) dut (
    .clk     (clk),
    .Rst     (rst),
    .Cnt     (cnt),
    .InsM    (ins_m),
    .InsL    (ins_l),
    .Buff_PC (buff_pc)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Run one instruction from Cnt=0 with the controller counter model until
  // Buff_PC rises (or 16 cycles pass), then confirm the restart at Cnt=0.
  task automatic run_instr(input string tag, input logic [4:0] m, input logic [1:0] l,
                           input logic [2:0] exp_last);
    logic       done;
    logic       seen;
    logic [7:0] want;
    exp_q.push_back({5'd0, exp_last});
    @(posedge clk);
    ins_m = m;
    ins_l = l;
    cnt   = 3'd0;
    done  = 1'b0;
    for (int c = 0; c < 16 && !done; c++) begin
      @(negedge clk);
      seen = buff_pc;
      if (seen === 1'b1) begin
        want = exp_q.pop_front();
        check({tag, "_pulse_cnt"}, {5'd0, cnt}, want);
        done = 1'b1;
      end
      @(posedge clk);
      cnt = (seen === 1'b1) ? 3'd0 : cnt + 3'd1;
    end
    if (!done) begin
      want = exp_q.pop_front();
      check({tag, "_timeout"}, 8'd0, 8'd1);
    end else begin
      @(negedge clk);
      check({tag, "_restart"}, {7'd0, buff_pc}, 8'd0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    cnt   = 3'd0;
    ins_m = 5'b00000;
    ins_l = 2'b00;

    // Reset forces Buff_PC low for every Cnt
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      cnt = 3'(i);
      @(negedge clk);
      check("rst_sweep", {7'd0, buff_pc}, 8'd0);
    end
    @(posedge clk);
    rst = 1'b0;
    cnt = 3'd0;
    @(negedge clk);
    check("rst_release_cnt0", {7'd0, buff_pc}, 8'd0);

    run_instr("ldrri", 5'b00011, 2'b00, 3'd4);
    run_instr("strri", 5'b00101, 2'b00, 3'd3);
    run_instr("lhi",   5'b00001, 2'b00, 3'd2);
    run_instr("strrr", 5'b00110, 2'b00, 3'd3);
    run_instr("cmp",   5'b00110, 2'b01, 3'd2);
    run_instr("op6_l2", 5'b00110, 2'b10, 3'd2);
    run_instr("op6_l3", 5'b00110, 2'b11, 3'd2);
    for (int l = 0; l < 4; l++) run_instr("alu", 5'b00000, 2'(l), 3'd3);
    run_instr("bcond", 5'b11000, 2'b00, 3'd2);
    run_instr("bal",   5'b11001, 2'b00, 3'd2);
    run_instr("jalrl", 5'b10001, 2'b00, 3'd3);
    run_instr("jr",    5'b10011, 2'b00, 3'd2);
    run_instr("outr",  5'b11100, 2'b00, 3'd2);
    run_instr("hlt",   5'b11100, 2'b01, 3'd2);
    run_instr("io_l3", 5'b11100, 2'b11, 3'd2);
    run_instr("undef", 5'b11111, 2'b00, 3'd2);
    run_instr("undef_rnd", 5'b01001 + 5'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'd2);

    // Overrun counter must still terminate
    @(posedge clk);
    ins_m = 5'b00011;
    ins_l = 2'b00;
    cnt   = 3'd7;
    @(negedge clk);
    check("overrun_cnt7", {7'd0, buff_pc}, 8'd1);
    @(posedge clk);
    cnt = 3'd3;
    @(negedge clk);
    check("ldrri_cnt3_low", {7'd0, buff_pc}, 8'd0);

    // Reset mid-instruction drops Buff_PC immediately
    @(posedge clk);
    cnt = 3'd4;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_instr", {7'd0, buff_pc}, 8'd0);
    @(posedge clk);
    rst = 1'b0;
    cnt = 3'd0;
    @(negedge clk);
    check("rst_mid_release", {7'd0, buff_pc}, 8'd0);

    // Back-to-back sweep of every defined instruction
    for (int i = 0; i < 25; i++) begin
      logic [9:0] e;
      e = SWEEP[i];
      run_instr($sformatf("sweep%0d", i), e[9:5], e[4:3], e[2:0]);
    end

    check("scoreboard_empty", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/buff_pc_signal_gen.md
Name: buff_pc_signal_gen

Overview:
- Control-signal generator inside the multicycle RISC controller.
- Asserts Buff_PC on the final cycle of every instruction. This tells the datapath to latch the next PC and tells the controller to restart its cycle counter Cnt at 0.
- The cycle length is decoded from opcode InsM[15:11] and function field InsL[1:0].
- It is a pure decode of Cnt/InsM/InsL/Rst. The counter itself lives in the controller.

Parameters:
- CNT_W, 3, width of cycle counter Cnt.

Ports:
- clk  input  1  controller clock. Interface uniformity only; the Buff_PC path is combinational and the block holds no state.
- Rst  input  1  reset, synchronous, active-high. When high, the controller clears Cnt to 0 at the next clk rising edge. This block forces Buff_PC=0 while Rst=1.
- Cnt  input  CNT_W  current cycle of the instruction. 0 = fetch, 1 = decode (instruction valid from Cnt=1).
- InsM  input  5  instruction bits [15:11] (major opcode).
- InsL  input  2  instruction bits [1:0] (function select).
- Buff_PC  output  1  high in the last cycle of the current instruction.

Behaviour:
- Buff_PC = !Rst && (Cnt >= 1) && (Cnt >= LAST(InsM,InsL)). Purely combinational, zero latency.
- The >= comparison guarantees a counter past the terminal value still terminates, so the controller cannot lock up.
- Rst=1 gives Buff_PC=0 regardless of other inputs. Cnt=0 gives Buff_PC=0 always.
- LAST table (Cnt value at which Buff_PC rises):
  - 00000 (ADD L=00, ADC L=01, SUB L=10, SBB L=11): 3
  - 00001 LHI, 00010 LLI: 2
  - 00011 LDRri: 4
  - 00100 LDRrr: 4 for any InsL
  - 00101 STRri: 3
  - 00110 with L=00 STRrr: 3
  - 00110 with L=01 CMP: 2
  - 00110 with L=1x: 2
  - 00111 ADDI, 01000 SUBI: 3
  - 01011 MOV: 2
  - 11000 conditional branches (BCC/BCS/BEQ/BNE): 2
  - 11001 BAL: 2
  - 10000 JMP: 2
  - 10001 JALrl, 10010 JALrr: 3
  - 10011 JR: 2
  - 11100 with L=00 OutR: 2
  - 11100 with L=01 HLT: 2. Halt is enforced by PC-write logic elsewhere; this block still terminates the cycle.
  - 11100 with L=1x: 2
  - Every other opcode (undefined): 2, treated as NOP.
- InsL affects the result only for opcode 00110. All other rows ignore InsL.
- Expected controller usage: on each clk edge, Cnt <= 0 if Buff_PC or Rst, else Cnt+1.
- Reset mid-instruction: Buff_PC drops to 0 immediately. The instruction restarts from Cnt=0 after Rst releases.
- X/unknown opcode inputs may propagate X. No X-masking is required.

Decomposition:
- Package buff_pc_pkg holds:
  - 5-bit opcode constants: OP_ALU, OP_LHI, OP_LLI, OP_LDRRI, OP_LDRRR, OP_STRRI, OP_STRRR_CMP, OP_ADDI, OP_SUBI, OP_MOV, OP_BCOND, OP_BAL, OP_JMP, OP_JALRL, OP_JALRR, OP_JR, OP_IO.
  - Function constants: F_STRRR=2'b00, F_CMP=2'b01, F_OUTR=2'b00, F_HLT=2'b01.
  - Cycle-length constants: LEN_SHORT=2, LEN_ALU=3, LEN_STORE=3, LEN_LOAD=4, LEN_JAL=3.
- One sub-module, buff_pc_len_decode: maps (InsM, InsL) to LAST (CNT_W bits). The top level does the compare and the Rst/Cnt gating.

Test Plan:
- Rst=1 with Cnt=0..7 and InsM=00000 -> Buff_PC=0 throughout. Then release Rst with Cnt=0 -> Buff_PC=0.
- Closed loop with counter model, LDRri (InsM=00011) -> Buff_PC=1 only at Cnt=4, and Cnt returns to 0 next cycle. STRri (00101) -> pulse at Cnt=3. LHI (00001) -> pulse at Cnt=2.
- Opcode 00110 -> InsL=00 pulses at Cnt=3 (STRrr); InsL=01 pulses at Cnt=2 (CMP). ALU 00000 with InsL=00/01/10/11 -> pulse at Cnt=3 for all four.
- Branch/jump: InsM=11000 or 11001 -> pulse at Cnt=2. JALrl 10001 -> pulse at Cnt=3. JR 10011 -> pulse at Cnt=2.
- IO: InsM=11100 with InsL=00 (OutR) and with InsL=01 (HLT) -> pulse at Cnt=2. Undefined opcode 11111 -> pulse at Cnt=2. Forced Cnt=7 with LDRri -> Buff_PC=1.
- Sweep all 25 defined instructions back-to-back with a 16-cycle timeout each -> every instruction terminates exactly at its LAST value, with no timeout.
